// File: rtl/atm_session_ctrl.sv
// Multi-account ATM session controller: card/PIN authentication with lockout,
// deposit/balance/withdraw menu, per-session withdrawal limit, idle timeout.
module atm_session_ctrl #(
  parameter int               N_ACCT      = 4,
  parameter int               BAL_W       = 16,
  parameter int               PIN_W       = 16,
  parameter logic [PIN_W-1:0] PIN_DEFAULT = 16'h1009,
  parameter int               INIT_BAL    = 5000,
  parameter int               MAX_TRIALS  = 3,
  parameter int               WD_LIMIT    = 2000,
  parameter int               TIMEOUT     = 1000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      card_in,
  input  logic [$clog2(N_ACCT)-1:0] card_id,
  input  logic                      pin_valid,
  input  logic [PIN_W-1:0]          pin,
  input  logic                      op_valid,
  input  logic [1:0]                op,
  input  logic [BAL_W-1:0]          amount,
  output logic                      resp_valid,
  output logic [2:0]                resp_code,
  output logic [BAL_W-1:0]          balance_out,
  output logic [1:0]                state_out,
  output logic                      session_active
);

  localparam int ACCT_W   = $clog2(N_ACCT);
  localparam int TRIALS_W = $clog2(MAX_TRIALS + 1);
  localparam int TMR_W    = $clog2(TIMEOUT + 1);

  localparam logic [BAL_W:0]       WD_LIM     = (BAL_W+1)'(WD_LIMIT);
  localparam logic [BAL_W-1:0]     BAL_INIT   = BAL_W'(INIT_BAL);
  localparam logic [TMR_W-1:0]     TMR_LAST   = TMR_W'(TIMEOUT - 1);
  localparam logic [TRIALS_W-1:0]  TRIALS_MAX = TRIALS_W'(MAX_TRIALS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_AUTH  = 2'd1,
    S_MENU  = 2'd2,
    S_EJECT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_DEP  = 2'd0,
    OP_BAL  = 2'd1,
    OP_WD   = 2'd2,
    OP_EXIT = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    RC_OK       = 3'd0,
    RC_BAD_PIN  = 3'd1,
    RC_LOCKED   = 3'd2,
    RC_INSUFF   = 3'd3,
    RC_LIMIT    = 3'd4,
    RC_OVERFLOW = 3'd5,
    RC_TIMEOUT  = 3'd6,
    RC_BYE      = 3'd7
  } resp_t;

  state_t                state, state_d;
  logic [ACCT_W-1:0]     acct, acct_d;
  logic [TRIALS_W-1:0]   trials, trials_d, trials_inc;
  logic [BAL_W-1:0]      wd_sum, wd_sum_d;
  logic [TMR_W-1:0]      tmr, tmr_d;
  logic [N_ACCT-1:0]     lock;
  logic                  lock_set;
  logic [BAL_W-1:0]      bal [N_ACCT];
  logic                  bal_we;
  logic [BAL_W-1:0]      bal_wdata;
  logic [BAL_W-1:0]      cur_bal;
  logic [BAL_W:0]        dep_sum, wd_total;
  logic                  resp_valid_d;
  resp_t                 resp_code_d;
  logic [BAL_W-1:0]      resp_bal_d;

  assign cur_bal    = bal[acct];
  assign dep_sum    = {1'b0, cur_bal} + {1'b0, amount};
  assign wd_total   = {1'b0, wd_sum} + {1'b0, amount};
  assign trials_inc = trials + TRIALS_W'(1);

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d      = state;
    acct_d       = acct;
    trials_d     = trials;
    wd_sum_d     = wd_sum;
    tmr_d        = '0;
    lock_set     = 1'b0;
    bal_we       = 1'b0;
    bal_wdata    = cur_bal;
    resp_valid_d = 1'b0;
    resp_code_d  = RC_OK;
    resp_bal_d   = cur_bal;

    unique case (state)
      S_IDLE: begin
        if (card_in) begin
          acct_d = card_id;
          if (lock[card_id]) begin
            resp_valid_d = 1'b1;
            resp_code_d  = RC_LOCKED;
            resp_bal_d   = bal[card_id];
            state_d      = S_EJECT;
          end else begin
            trials_d = '0;
            state_d  = S_AUTH;
          end
        end
      end

      S_AUTH: begin
        if (!card_in) begin
          state_d = S_IDLE;
        end else if (tmr == TMR_LAST) begin
          resp_valid_d = 1'b1;
          resp_code_d  = RC_TIMEOUT;
          state_d      = S_EJECT;
        end else if (pin_valid) begin
          resp_valid_d = 1'b1;
          if (pin == PIN_DEFAULT) begin
            trials_d    = '0;
            wd_sum_d    = '0;
            resp_code_d = RC_OK;
            state_d     = S_MENU;
          end else if (trials_inc == TRIALS_MAX) begin
            trials_d    = trials_inc;
            lock_set    = 1'b1;
            resp_code_d = RC_LOCKED;
            state_d     = S_EJECT;
          end else begin
            trials_d    = trials_inc;
            resp_code_d = RC_BAD_PIN;
          end
        end else begin
          tmr_d = tmr + TMR_W'(1);
        end
      end

      S_MENU: begin
        if (!card_in) begin
          state_d = S_IDLE;
        end else if (tmr == TMR_LAST) begin
          resp_valid_d = 1'b1;
          resp_code_d  = RC_TIMEOUT;
          state_d      = S_EJECT;
        end else if (op_valid) begin
          resp_valid_d = 1'b1;
          unique case (op_t'(op))
            OP_DEP: begin
              if (dep_sum[BAL_W]) begin
                resp_code_d = RC_OVERFLOW;
              end else begin
                bal_we      = 1'b1;
                bal_wdata   = dep_sum[BAL_W-1:0];
                resp_bal_d  = dep_sum[BAL_W-1:0];
              end
            end
            OP_BAL: ;
            OP_WD: begin
              // Insufficient funds outranks the session limit.
              if (amount > cur_bal) begin
                resp_code_d = RC_INSUFF;
              end else if (wd_total > WD_LIM) begin
                resp_code_d = RC_LIMIT;
              end else begin
                bal_we     = 1'b1;
                bal_wdata  = cur_bal - amount;
                resp_bal_d = cur_bal - amount;
                wd_sum_d   = wd_total[BAL_W-1:0];
              end
            end
            OP_EXIT: begin
              resp_code_d = RC_BYE;
              state_d     = S_EJECT;
            end
          endcase
        end else begin
          tmr_d = tmr + TMR_W'(1);
        end
      end

      S_EJECT: begin
        if (!card_in) state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      acct        <= '0;
      trials      <= '0;
      wd_sum      <= '0;
      tmr         <= '0;
      lock        <= '0;
      resp_valid  <= 1'b0;
      resp_code   <= '0;
      balance_out <= '0;
      // NOTE: the balance array is deliberately reset; every account must
      // restart at the initial balance, so it cannot map to a plain RAM.
      for (int i = 0; i < N_ACCT; i++) bal[i] <= BAL_INIT;
    end else begin
      state      <= state_d;
      acct       <= acct_d;
      trials     <= trials_d;
      wd_sum     <= wd_sum_d;
      tmr        <= tmr_d;
      resp_valid <= resp_valid_d;
      if (resp_valid_d) begin
        resp_code   <= resp_code_d;
        balance_out <= resp_bal_d;
      end
      if (lock_set) lock[acct] <= 1'b1;
      if (bal_we)   bal[acct]  <= bal_wdata;
    end
  end

  assign state_out      = state;
  assign session_active = (state == S_AUTH) || (state == S_MENU);

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed table-driven bench for atm_session_ctrl, plus hand-written
// timeout and asynchronous-reset sequences.
module tb_atm_session_ctrl;

  localparam logic [15:0] P = 16'h1009;
  localparam logic [1:0] IDLE = 2'd0, AUTH = 2'd1, MENU = 2'd2, EJECT = 2'd3;
  localparam logic [1:0] DEP = 2'd0, BAL = 2'd1, WD = 2'd2, EXIT = 2'd3;
  localparam logic [2:0] OK = 3'd0, BADP = 3'd1, LOCK = 3'd2, INS = 3'd3,
                         LIM = 3'd4, OVF = 3'd5, TMO = 3'd6, BYE = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        card_in;
  logic [1:0]  card_id;
  logic        pin_valid;
  logic [15:0] pin;
  logic        op_valid;
  logic [1:0]  op;
  logic [15:0] amount;
  logic        resp_valid;
  logic [2:0]  resp_code;
  logic [15:0] balance_out;
  logic [1:0]  state_out;
  logic        session_active;

  int n_checks = 0;
  int n_err    = 0;

  atm_session_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .card_in        (card_in),
    .card_id        (card_id),
    .pin_valid      (pin_valid),
    .pin            (pin),
    .op_valid       (op_valid),
    .op             (op),
    .amount         (amount),
    .resp_valid     (resp_valid),
    .resp_code      (resp_code),
    .balance_out    (balance_out),
    .state_out      (state_out),
    .session_active (session_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        card_in;
    logic [1:0]  card_id;
    logic        pin_valid;
    logic [15:0] pin;
    logic        op_valid;
    logic [1:0]  op;
    logic [15:0] amount;
    logic        exp_valid;
    logic [2:0]  exp_code;
    logic        chk_bal;
    logic [15:0] exp_bal;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ci, logic [1:0] id, logic pv, logic [15:0] pn,
                              logic ov, logic [1:0] o, logic [15:0] amt,
                              logic ev, logic [2:0] ec, logic cb, logic [15:0] eb,
                              logic [1:0] es);
    vec_t v;
    v.card_in = ci;  v.card_id = id;  v.pin_valid = pv; v.pin = pn;
    v.op_valid = ov; v.op = o;        v.amount = amt;
    v.exp_valid = ev; v.exp_code = ec; v.chk_bal = cb; v.exp_bal = eb;
    v.exp_state = es;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(vec_t v, string tag);
    card_in   = v.card_in;
    card_id   = v.card_id;
    pin_valid = v.pin_valid;
    pin       = v.pin;
    op_valid  = v.op_valid;
    op        = v.op;
    amount    = v.amount;
    @(posedge clk);
    #1;
    check({tag, ".state"}, 32'(state_out), 32'(v.exp_state));
    check({tag, ".active"}, 32'(session_active),
          32'(v.exp_state == AUTH || v.exp_state == MENU));
    check({tag, ".valid"}, 32'(resp_valid), 32'(v.exp_valid));
    if (v.exp_valid) check({tag, ".code"}, 32'(resp_code), 32'(v.exp_code));
    if (v.chk_bal)   check({tag, ".bal"}, 32'(balance_out), 32'(v.exp_bal));
  endtask

  task automatic run_table(string tag);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("%s%0d", tag, i));
    vecs.delete();
  endtask

  initial begin
    rst_n = 1'b0; card_in = 1'b0; card_id = '0; pin_valid = 1'b0; pin = '0;
    op_valid = 1'b0; op = '0; amount = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst.state", 32'(state_out), 32'(IDLE));
    check("rst.valid", 32'(resp_valid), 0);
    check("rst.code", 32'(resp_code), 0);
    check("rst.bal", 32'(balance_out), 0);
    check("rst.active", 32'(session_active), 0);

    // Account 2: balance query, withdrawal limit across sessions, INSUFF, zero amounts.
    vecs.push_back(mk(1,2,0,0,0,0,0,     0,OK,0,0,AUTH));
    vecs.push_back(mk(1,2,1,P,0,0,0,     1,OK,0,0,MENU));
    vecs.push_back(mk(1,2,0,0,1,BAL,0,   1,OK,1,5000,MENU));
    vecs.push_back(mk(1,2,0,0,1,WD,1500, 1,OK,1,3500,MENU));
    vecs.push_back(mk(1,2,0,0,1,WD,600,  1,LIM,1,3500,MENU));
    vecs.push_back(mk(1,2,0,0,1,EXIT,0,  1,BYE,1,3500,EJECT));
    vecs.push_back(mk(1,2,0,0,0,0,0,     0,OK,0,0,EJECT));
    vecs.push_back(mk(0,2,0,0,0,0,0,     0,OK,0,0,IDLE));
    vecs.push_back(mk(1,2,0,0,0,0,0,     0,OK,0,0,AUTH));
    vecs.push_back(mk(1,2,1,P,0,0,0,     1,OK,0,0,MENU));
    vecs.push_back(mk(1,2,0,0,1,WD,600,  1,OK,1,2900,MENU));
    vecs.push_back(mk(1,2,0,0,1,WD,3000, 1,INS,1,2900,MENU));
    vecs.push_back(mk(1,2,0,0,1,WD,0,    1,OK,1,2900,MENU));
    vecs.push_back(mk(1,2,0,0,1,DEP,0,   1,OK,1,2900,MENU));
    vecs.push_back(mk(1,2,0,0,1,DEP,100, 1,OK,1,3000,MENU));
    vecs.push_back(mk(1,2,0,0,1,EXIT,0,  1,BYE,1,3000,EJECT));
    vecs.push_back(mk(0,2,0,0,0,0,0,     0,OK,0,0,IDLE));
    // Account 1: lockout after three wrong PINs; op strobe ignored in AUTH.
    vecs.push_back(mk(1,1,0,0,0,0,0,          0,OK,0,0,AUTH));
    vecs.push_back(mk(1,1,1,16'h1234,0,0,0,   1,BADP,0,0,AUTH));
    vecs.push_back(mk(1,1,0,0,1,DEP,5,        0,OK,0,0,AUTH));
    vecs.push_back(mk(1,1,1,16'h0000,0,0,0,   1,BADP,0,0,AUTH));
    vecs.push_back(mk(1,1,1,16'h1008,0,0,0,   1,LOCK,0,0,EJECT));
    vecs.push_back(mk(0,1,0,0,0,0,0,          0,OK,0,0,IDLE));
    vecs.push_back(mk(1,1,0,0,0,0,0,          1,LOCK,1,5000,EJECT));
    vecs.push_back(mk(0,1,0,0,0,0,0,          0,OK,0,0,IDLE));
    // Account 0: deposit overflow, PIN ignored in MENU, card pulled with a strobe.
    vecs.push_back(mk(1,0,0,0,0,0,0,          0,OK,0,0,AUTH));
    vecs.push_back(mk(1,0,1,P,0,0,0,          1,OK,0,0,MENU));
    vecs.push_back(mk(1,0,0,0,1,DEP,60535,    1,OK,1,65535,MENU));
    vecs.push_back(mk(1,0,0,0,1,DEP,1,        1,OVF,1,65535,MENU));
    vecs.push_back(mk(1,0,1,16'h4444,0,0,0,   0,OK,1,65535,MENU));
    vecs.push_back(mk(0,0,0,0,1,WD,100,       0,OK,1,65535,IDLE));
    vecs.push_back(mk(1,0,0,0,0,0,0,          0,OK,0,0,AUTH));
    vecs.push_back(mk(1,0,1,P,0,0,0,          1,OK,0,0,MENU));
    vecs.push_back(mk(1,0,0,0,1,BAL,0,        1,OK,1,65535,MENU));
    run_table("a");

    // Idle in MENU: the TIMEOUT pulse must land on the 1000th edge after the last strobe.
    begin
      int n;
      pin_valid = 1'b0; op_valid = 1'b0;
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!resp_valid && n < 1100);
      check("tmo.cycles", 32'(n), 1000);
      check("tmo.code", 32'(resp_code), 32'(TMO));
      check("tmo.state", 32'(state_out), 32'(EJECT));
      @(posedge clk); #1;
      check("tmo.pulse_len", 32'(resp_valid), 0);
    end
    vecs.push_back(mk(0,0,0,0,0,0,0, 0,OK,0,0,IDLE));
    vecs.push_back(mk(1,0,0,0,0,0,0, 0,OK,0,0,AUTH));
    vecs.push_back(mk(1,0,1,P,0,0,0, 1,OK,0,0,MENU));
    run_table("b");

    // Asynchronous reset mid-session, with a strobe pending.
    op_valid = 1'b1; op = WD; amount = 16'd10;
    #2 rst_n = 1'b0;
    #1;
    check("arst.state", 32'(state_out), 32'(IDLE));
    check("arst.valid", 32'(resp_valid), 0);
    check("arst.bal", 32'(balance_out), 0);
    check("arst.active", 32'(session_active), 0);
    @(negedge clk) rst_n = 1'b1;
    op_valid = 1'b0; card_in = 1'b0;

    // After reset: account 1 unlocked, every balance back to 5000.
    vecs.push_back(mk(0,1,0,0,0,0,0,    0,OK,0,0,IDLE));
    vecs.push_back(mk(1,1,0,0,0,0,0,    0,OK,0,0,AUTH));
    vecs.push_back(mk(1,1,1,P,0,0,0,    1,OK,0,0,MENU));
    vecs.push_back(mk(1,1,0,0,1,BAL,0,  1,OK,1,5000,MENU));
    vecs.push_back(mk(1,1,0,0,1,EXIT,0, 1,BYE,1,5000,EJECT));
    vecs.push_back(mk(0,1,0,0,0,0,0,    0,OK,0,0,IDLE));
    vecs.push_back(mk(1,0,0,0,0,0,0,    0,OK,0,0,AUTH));
    vecs.push_back(mk(1,0,1,P,0,0,0,    1,OK,0,0,MENU));
    vecs.push_back(mk(1,0,0,0,1,BAL,0,  1,OK,1,5000,MENU));
    vecs.push_back(mk(1,2,0,0,1,EXIT,0, 1,BYE,1,5000,EJECT));
    vecs.push_back(mk(0,2,0,0,0,0,0,    0,OK,0,0,IDLE));
    vecs.push_back(mk(1,2,0,0,0,0,0,    0,OK,0,0,AUTH));
    vecs.push_back(mk(1,2,1,P,0,0,0,    1,OK,0,0,MENU));
    vecs.push_back(mk(1,2,0,0,1,BAL,0,  1,OK,1,5000,MENU));
    run_table("c");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
